prime_test: RTL and testbench

PRIME_TEST -- requirements
Module: prime_test

---
 rtl/prime_test_pkg.sv | 20 ++
 rtl/prime_test_divrem.sv | 70 +++++++
 rtl/prime_test.sv | 174 +++++++++++++++++
 tb/tb_prime_test.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/prime_test_pkg.sv
// prime_test_pkg: shared FSM encoding and operand width derivation for prime_test
package prime_test_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        POLL  = 3'd3,
        DONE  = 3'd4
    } state_e;

    function automatic int width_of(input int width_log);
        return 1 << width_log;
    endfunction

    function automatic int hi_of(input int width_log);
        return width_of(width_log) - 1;
    endfunction

endpackage

// File: rtl/prime_test_divrem.sv
// prime_test_divrem: restoring serial divider returning the remainder, one quotient bit per cycle
module prime_test_divrem
    import prime_test_pkg::*;
#(
    parameter int WIDTH_LOG = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            go_i,
    input  logic [width_of(WIDTH_LOG)-1:0]  num_i,
    input  logic [width_of(WIDTH_LOG)-1:0]  den_i,
    output logic                            ready_o,
    output logic [width_of(WIDTH_LOG)-1:0]  rem_o,
    output logic                            error_o
);

    localparam int WIDTH = width_of(WIDTH_LOG);
    localparam int CW    = WIDTH_LOG + 1;

    logic             ready_q;
    logic             busy_q;
    logic             err_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] den_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   diff;

    // shift the next dividend bit into the partial remainder and trial-subtract the divisor
    always_comb begin
        sh   = {rem_q, quo_q[WIDTH-1]};
        diff = sh - {1'b0, den_q};
    end

    // accept a request when idle, then produce one quotient bit per cycle; zero divisor flags error
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            den_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else if (go_i && ready_q) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            err_q   <= (den_i == '0);
            cnt_q   <= CW'(WIDTH);
            den_q   <= den_i;
            quo_q   <= num_i;
            rem_q   <= '0;
        end else if (busy_q) begin
            if (err_q || cnt_q == '0) begin
                busy_q  <= 1'b0;
                ready_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - 1'b1;
                rem_q <= diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
                quo_q <= {quo_q[WIDTH-2:0], ~diff[WIDTH]};
            end
        end
    end

    assign ready_o = ready_q;
    assign rem_o   = rem_q;
    assign error_o = err_q;

endmodule

// File: rtl/prime_test.sv
// prime_test: trial-division primality tester driving a serial divrem with 2, 3, 5, 7, ... up to sqrt(n)
module prime_test
    import prime_test_pkg::*;
#(
    parameter int WIDTH_LOG = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            go,
    input  logic [width_of(WIDTH_LOG)-1:0]  num,
    output logic                            ready,
    output logic                            is_prime,
    output logic [width_of(WIDTH_LOG)-1:0]  factor,
    output logic                            error
);

    localparam int WIDTH = width_of(WIDTH_LOG);
    localparam int HI    = hi_of(WIDTH_LOG);

    state_e            state_q, state_d;
    logic   [HI:0]     n_q, n_d;
    logic   [HI:0]     d_q, d_d;
    logic   [HI:0]     d_nx;
    logic   [HI:0]     fac_q, fac_d;
    logic   [HI:0]     pfac_q, pfac_d;
    logic              ready_q, ready_d;
    logic              prime_q, prime_d;
    logic              pprime_q, pprime_d;
    logic              err_q, err_d;
    logic              perr_q, perr_d;
    logic   [2*WIDTH-1:0] sq;
    logic              accept;
    logic              trivial;
    logic              div_go;
    logic              div_ready;
    logic              div_err;
    logic   [HI:0]     div_rem;

    // request acceptance, next odd divisor and its square at double width so it cannot overflow
    always_comb begin
        accept  = go && ready_q;
        trivial = num < WIDTH'(4);
        d_nx    = (d_q == WIDTH'(2)) ? WIDTH'(3) : d_q + WIDTH'(2);
        sq      = {{WIDTH{1'b0}}, d_nx} * {{WIDTH{1'b0}}, d_nx};
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // next-state logic: issue a trial, skip the stale ready cycle, poll, then finish or retry
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = trivial ? DONE : ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = POLL;
            POLL:    if (div_ready)
                         state_d = (div_err || div_rem == '0 || sq > {{WIDTH{1'b0}}, n_q}) ? DONE : ISSUE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // output and datapath logic: verdict is staged as pending and published only when ready rises
    always_comb begin
        div_go   = (state_q == ISSUE);
        n_d      = n_q;
        d_d      = d_q;
        ready_d  = ready_q;
        prime_d  = prime_q;
        fac_d    = fac_q;
        err_d    = err_q;
        pprime_d = pprime_q;
        pfac_d   = pfac_q;
        perr_d   = perr_q;
        unique case (state_q)
            IDLE: if (accept) begin
                n_d      = num;
                d_d      = WIDTH'(2);
                ready_d  = 1'b0;
                err_d    = 1'b0;
                pprime_d = num >= WIDTH'(2);
                pfac_d   = '0;
                perr_d   = 1'b0;
            end
            POLL: if (div_ready) begin
                if (div_err) begin
                    perr_d   = 1'b1;
                    pprime_d = 1'b0;
                    pfac_d   = '0;
                end else if (div_rem == '0) begin
                    pprime_d = 1'b0;
                    pfac_d   = d_q;
                end else begin
                    d_d      = d_nx;
                    pprime_d = 1'b1;
                    pfac_d   = '0;
                end
            end
            DONE: begin
                ready_d = 1'b1;
                prime_d = pprime_q;
                fac_d   = pfac_q;
                err_d   = perr_q;
            end
            default: ;
        endcase
    end

    // datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q      <= '0;
            d_q      <= '0;
            ready_q  <= 1'b1;
            prime_q  <= 1'b0;
            fac_q    <= '0;
            err_q    <= 1'b0;
            pprime_q <= 1'b0;
            pfac_q   <= '0;
            perr_q   <= 1'b0;
        end else begin
            n_q      <= n_d;
            d_q      <= d_d;
            ready_q  <= ready_d;
            prime_q  <= prime_d;
            fac_q    <= fac_d;
            err_q    <= err_d;
            pprime_q <= pprime_d;
            pfac_q   <= pfac_d;
            perr_q   <= perr_d;
        end
    end

    prime_test_divrem #(.WIDTH_LOG(WIDTH_LOG)) u_div (
        .clk     (clk),
        .rst     (rst),
        .go_i    (div_go),
        .num_i   (n_q),
        .den_i   (d_q),
        .ready_o (div_ready),
        .rem_o   (div_rem),
        .error_o (div_err)
    );

    assign ready    = ready_q;
    assign is_prime = prime_q;
    assign factor   = fac_q;
    assign error    = err_q;

`ifdef SIM
    // accepted requests must carry known control and operand values
    always @(posedge clk) begin
        if (go && ready_q && !rst)
            assert (!$isunknown({rst, clk, num})) else $error("prime_test: X on rst/clk/num at go");
    end

    // the caller must hold the candidate while the test is running
    always @(posedge clk) begin
        if (!rst && !ready_q)
            assert (num == n_q) else $error("prime_test: num changed while busy");
    end

    // a reported factor must really divide the candidate
    always @(posedge clk) begin
        if (!rst && state_q == DONE && !pprime_q && pfac_q != '0)
            assert (n_q % pfac_q == '0) else $error("prime_test: factor does not divide n");
    end
`endif

endmodule

// File: tb/tb_prime_test.sv
// tb_prime_test: directed and random checks of prime_test against a brute-force primality model
module tb_prime_test;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [15:0] num;
    logic        ready;
    logic        is_prime;
    logic [15:0] factor;
    logic        error;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc;

    prime_test #(.WIDTH_LOG(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .num      (num),
        .ready    (ready),
        .is_prime (is_prime),
        .factor   (factor),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input int n, output logic p, output logic [15:0] f);
        p = (n >= 2);
        f = '0;
        for (int d = 2; d * d <= n && f == 0; d++)
            if (n % d == 0) begin
                p = 1'b0;
                f = 16'(d);
            end
    endfunction

    task automatic wait_done(output int cycles, output bit stable);
        logic        hp;
        logic [15:0] hf;
        hp     = is_prime;
        hf     = factor;
        cycles = 0;
        stable = 1'b1;
        while (!ready && cycles < 6000) begin
            cycles++;
            if (is_prime !== hp || factor !== hf) stable = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic run(input int n, input string tag, output int cycles);
        logic        p;
        logic [15:0] f;
        bit          stable;
        model(n, p, f);
        @(negedge clk);
        num = 16'(n);
        go  = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_done(cycles, stable);
        check({tag, " ready"}, 32'(ready), 32'd1);
        check({tag, " busy"}, 32'(cycles != 0), 32'd1);
        check({tag, " is_prime"}, 32'(is_prime), 32'(p));
        check({tag, " factor"}, 32'(factor), 32'(f));
        check({tag, " error"}, 32'(error), 32'd0);
        check({tag, " hold"}, 32'(stable), 32'd1);
    endtask

    initial begin
        bit stable;
        rst = 1'b1;
        go  = 1'b0;
        num = '0;
        repeat (2) @(negedge clk);
        check("reset ready", 32'(ready), 32'd1);
        check("reset is_prime", 32'(is_prime), 32'd0);
        check("reset factor", 32'(factor), 32'd0);
        check("reset error", 32'(error), 32'd0);
        rst = 1'b0;

        for (int n = 0; n < 4; n++) begin
            run(n, $sformatf("trivial %0d", n), cyc);
            check($sformatf("trivial %0d cycles", n), 32'(cyc), 32'd1);
        end

        @(negedge clk);
        num = '0;
        go  = 1'b1;
        @(negedge clk);
        check("go held busy", 32'(ready), 32'd0);
        @(negedge clk);
        check("go at rise ignored", 32'(ready), 32'd1);
        go = 1'b0;
        @(negedge clk);
        check("go at rise idle", 32'(ready), 32'd1);

        run(4, "n4", cyc);
        run(91, "n91", cyc);
        run(97, "n97", cyc);
        run(65535, "n65535", cyc);
        run(65521, "n65521", cyc);
        run(25, "n25", cyc);
        run(49, "n49", cyc);

        @(negedge clk);
        num = 16'd91;
        go  = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (3) @(negedge clk);
        num = 16'd97;
        go  = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_done(cyc, stable);
        check("busy go ready", 32'(ready), 32'd1);
        check("busy go is_prime", 32'(is_prime), 32'd0);
        check("busy go factor", 32'(factor), 32'd7);

        @(negedge clk);
        num = 16'd65521;
        go  = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (40) @(negedge clk);
        check("abort busy", 32'(ready), 32'd0);
        rst = 1'b1;
        go  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        go  = 1'b0;
        check("abort ready", 32'(ready), 32'd1);
        check("abort is_prime", 32'(is_prime), 32'd0);
        check("abort factor", 32'(factor), 32'd0);
        check("abort error", 32'(error), 32'd0);
        repeat (40) @(negedge clk);
        check("abort no update", 32'(factor), 32'd0);
        check("abort still idle", 32'(ready), 32'd1);
        run(13, "after rst 13", cyc);

        for (int i = 0; i < 12; i++) run(int'($urandom_range(0, 300)), $sformatf("rand small %0d", i), cyc);
        for (int i = 0; i < 12; i++) run(int'($urandom_range(0, 65535)), $sformatf("rand big %0d", i), cyc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
